// File: rtl/pmci_vdm_msg_assembler.sv
// PMCI VDM message assembler: reassembles MCTP-over-VDM TLPs into whole messages in a
// committed payload buffer. Define PMCI_VDM_ERR_CNT_EN to add per-class error counters (err_cnt).
module pmci_vdm_msg_assembler #(
  parameter int BUF_DEPTH  = 512,
  parameter int MAX_MSG_DW = 256
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       vdm_valid,
  output logic                       vdm_ready,
  input  logic [31:0]                vdm_data,
  input  logic                       vdm_sop,
  input  logic                       vdm_eop,
  input  logic                       vdm_som,
  input  logic                       vdm_eom,
  input  logic [1:0]                 vdm_seq,
  input  logic [2:0]                 vdm_tag,
  input  logic [7:0]                 vdm_src_eid,
  input  logic                       rd_en,
  output logic [31:0]                rd_data,
  output logic [$clog2(BUF_DEPTH):0] rd_avail,
  output logic                       msg_done,
  output logic [8:0]                 msg_len,
  output logic [4:0]                 err_sts,
  input  logic [4:0]                 err_clr
`ifdef PMCI_VDM_ERR_CNT_EN
 ,output logic [79:0]                err_cnt
`endif
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(MAX_MSG_DW + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_MSG_DW);

  typedef enum logic [1:0] {IDLE, ASSEMBLE, DROP} state_t;

  state_t state, state_nxt;

  logic [31:0]   mem [BUF_DEPTH];
  logic [AW:0]   wr_ptr, commit_ptr, rd_ptr;
  logic [CW-1:0] msg_cnt;
  logic [1:0]    exp_seq;
  logic [2:0]    tag_q;
  logic [7:0]    eid_q;
  logic          eom_q;

  logic          accept, restart, hdr_bad, tlp_eom, pop;
  logic [AW:0]   base_ptr;
  logic [CW-1:0] base_cnt, cnt_inc;
  logic          full, ovf;
  logic          wr_req, wr_go, rewind, commit, seq_adv;
  logic [4:0]    err_set;

  assign accept   = vdm_valid & vdm_ready;
  assign restart  = accept & vdm_sop & vdm_som & (state != DROP);
  assign hdr_bad  = (vdm_tag != tag_q) || (vdm_src_eid != eid_q);
  assign tlp_eom  = vdm_sop ? vdm_eom : eom_q;

  // A new message always starts at the commit pointer, discarding any partial one.
  assign base_ptr = restart ? commit_ptr : wr_ptr;
  assign base_cnt = restart ? '0 : msg_cnt;
  assign cnt_inc  = base_cnt + CW'(1);
  assign full     = (base_ptr[AW] != rd_ptr[AW]) && (base_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign ovf      = (base_cnt == MAX_CNT) || full;

  assign rd_avail = commit_ptr - rd_ptr;
  assign pop      = rd_en && (rd_avail != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    err_set   = '0;
    wr_req    = 1'b0;
    rewind    = 1'b0;
    seq_adv   = 1'b0;
    wr_go     = 1'b0;
    commit    = 1'b0;
    if (accept) begin
      case (state)
        IDLE: begin
          if (vdm_sop && vdm_som) begin
            wr_req = 1'b1;
          end else if (vdm_sop) begin
            err_set[0] = 1'b1;
            if (!vdm_eop) state_nxt = DROP;
          end
        end
        // A one-beat TLP has already ended, so errors on it return to IDLE rather than DROP.
        ASSEMBLE: begin
          if (restart) begin
            err_set[1] = 1'b1;
            wr_req     = 1'b1;
          end else if (vdm_sop && (vdm_seq != exp_seq)) begin
            err_set[2] = 1'b1;
            rewind     = 1'b1;
            state_nxt  = vdm_eop ? IDLE : DROP;
          end else if (vdm_sop && hdr_bad) begin
            err_set[3] = 1'b1;
            rewind     = 1'b1;
            state_nxt  = vdm_eop ? IDLE : DROP;
          end else begin
            wr_req  = 1'b1;
            seq_adv = vdm_sop;
          end
        end
        DROP: begin
          if (vdm_eop) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
    if (wr_req) begin
      if (ovf) begin
        err_set[4] = 1'b1;
        rewind     = 1'b1;
        state_nxt  = vdm_eop ? IDLE : DROP;
      end else begin
        wr_go = 1'b1;
        if (vdm_eop && tlp_eom) begin
          commit    = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = ASSEMBLE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_go) mem[base_ptr[AW-1:0]] <= vdm_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vdm_ready  <= 1'b0;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      msg_cnt    <= '0;
      exp_seq    <= '0;
      tag_q      <= '0;
      eid_q      <= '0;
      eom_q      <= 1'b0;
      rd_data    <= '0;
      msg_done   <= 1'b0;
      msg_len    <= '0;
      err_sts    <= '0;
    end else begin
      vdm_ready <= 1'b1;
      msg_done  <= commit;
      if (restart) begin
        tag_q   <= vdm_tag;
        eid_q   <= vdm_src_eid;
        exp_seq <= vdm_seq + 2'd1;
      end else if (seq_adv) begin
        exp_seq <= exp_seq + 2'd1;
      end
      if (accept && vdm_sop) eom_q <= vdm_eom;
      if (wr_go) begin
        wr_ptr  <= base_ptr + 1'b1;
        msg_cnt <= cnt_inc;
      end else if (rewind) begin
        wr_ptr  <= commit_ptr;
        msg_cnt <= '0;
      end
      if (commit) begin
        commit_ptr <= base_ptr + 1'b1;
        msg_len    <= 9'(cnt_inc);
      end
      if (pop) begin
        rd_data <= mem[rd_ptr[AW-1:0]];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      err_sts <= (err_sts & ~err_clr) | err_set;
    end
  end

`ifdef PMCI_VDM_ERR_CNT_EN
  logic [4:0][15:0] cnt_q;

  // Clear beats a simultaneous increment, so software reading then clearing loses nothing stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (err_clr[i])                           cnt_q[i] <= '0;
        else if (err_set[i] && cnt_q[i] != '1)    cnt_q[i] <= cnt_q[i] + 16'd1;
      end
    end
  end

  assign err_cnt = cnt_q;
`else
  // Only the sticky err_sts flags record errors in this build.
`endif

endmodule

// File: tb/tb_pmci_vdm_msg_assembler.sv
// Self-checking bench for pmci_vdm_msg_assembler: randomized TLP streams checked every cycle
// against a queue-based message model, plus directed scenarios with literal expectations.
module tb_pmci_vdm_msg_assembler;

  localparam int BUF_DEPTH  = 512;
  localparam int MAX_MSG_DW = 256;
  localparam int AW         = $clog2(BUF_DEPTH);

  logic          clk;
  logic          rst_n;
  logic          vdm_valid, vdm_ready;
  logic [31:0]   vdm_data;
  logic          vdm_sop, vdm_eop, vdm_som, vdm_eom;
  logic [1:0]    vdm_seq;
  logic [2:0]    vdm_tag;
  logic [7:0]    vdm_src_eid;
  logic          rd_en;
  logic [31:0]   rd_data;
  logic [AW:0]   rd_avail;
  logic          msg_done;
  logic [8:0]    msg_len;
  logic [4:0]    err_sts;
  logic [4:0]    err_clr;
`ifdef PMCI_VDM_ERR_CNT_EN
  logic [79:0]   err_cnt;
`endif

  pmci_vdm_msg_assembler #(.BUF_DEPTH(BUF_DEPTH), .MAX_MSG_DW(MAX_MSG_DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .vdm_valid(vdm_valid), .vdm_ready(vdm_ready), .vdm_data(vdm_data),
    .vdm_sop(vdm_sop), .vdm_eop(vdm_eop), .vdm_som(vdm_som), .vdm_eom(vdm_eom),
    .vdm_seq(vdm_seq), .vdm_tag(vdm_tag), .vdm_src_eid(vdm_src_eid),
    .rd_en(rd_en), .rd_data(rd_data), .rd_avail(rd_avail),
    .msg_done(msg_done), .msg_len(msg_len), .err_sts(err_sts), .err_clr(err_clr)
`ifdef PMCI_VDM_ERR_CNT_EN
   ,.err_cnt(err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: committed-unread DWs, the partial message, and the message context.
  bit [31:0] fifo[$];
  bit [31:0] pend[$];
  bit        m_asm, m_drop, m_eom;
  bit [1:0]  m_seq;
  bit [2:0]  m_tag;
  bit [7:0]  m_eid;

  bit        exp_ready, exp_done;
  int        exp_avail, exp_len;
  bit [4:0]  exp_err;
  bit [31:0] exp_rd;
  int        exp_cnt[5];

  int n_vec, n_err, rd_prob, last_len, done_cnt;
  bit chk_en;

  task automatic cmp(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    if (msg_done) begin
      last_len = int'(msg_len);
      done_cnt++;
    end
    cmp("vdm_ready", longint'(vdm_ready), longint'(exp_ready));
    cmp("rd_avail",  longint'(rd_avail),  longint'(exp_avail));
    cmp("msg_done",  longint'(msg_done),  longint'(exp_done));
    cmp("msg_len",   longint'(msg_len),   longint'(exp_len));
    cmp("err_sts",   longint'(err_sts),   longint'(exp_err));
    cmp("rd_data",   longint'(rd_data),   longint'(exp_rd));
`ifdef PMCI_VDM_ERR_CNT_EN
    for (int i = 0; i < 5; i++)
      cmp("err_cnt", longint'(err_cnt[i*16 +: 16]), longint'(exp_cnt[i]));
`endif
  endtask

  always @(negedge clk) if (chk_en) checkOutput();

  function automatic void abandon(input bit eop);
    pend.delete();
    m_asm  = 1'b0;
    m_drop = !eop;
  endfunction

  function automatic bit rd_pick();
    return $urandom_range(0, 99) < rd_prob;
  endfunction

  // One clock of stimulus; the model predicts every output seen after the next rising edge.
  task automatic applyStimulus(input bit v, input bit sop, input bit eop, input bit som,
                               input bit eom, input bit [1:0] seq, input bit [2:0] tag,
                               input bit [7:0] eid, input bit [31:0] data, input bit rd,
                               input bit [4:0] clr);
    bit can_pop, wr;
    bit [4:0] set;
    @(negedge clk);
    #1;
    vdm_valid = v;  vdm_sop = sop;  vdm_eop = eop;  vdm_som = som;  vdm_eom = eom;
    vdm_seq = seq;  vdm_tag = tag;  vdm_src_eid = eid;  vdm_data = data;
    rd_en = rd;  err_clr = clr;
    can_pop  = rd && (fifo.size() > 0);
    set      = '0;
    wr       = 1'b0;
    exp_done = 1'b0;
    if (v && exp_ready) begin
      if (sop) m_eom = eom;
      if (m_drop) begin
        if (eop) m_drop = 1'b0;
      end else if (sop && som) begin
        if (m_asm) set[1] = 1'b1;
        pend.delete();
        m_asm = 1'b1;  m_tag = tag;  m_eid = eid;  m_seq = seq + 2'd1;
        wr = 1'b1;
      end else if (sop && !m_asm) begin
        set[0] = 1'b1;
        m_drop = !eop;
      end else if (sop && seq != m_seq) begin
        set[2] = 1'b1;
        abandon(eop);
      end else if (sop && (tag != m_tag || eid != m_eid)) begin
        set[3] = 1'b1;
        abandon(eop);
      end else if (m_asm) begin
        if (sop) m_seq = m_seq + 2'd1;
        wr = 1'b1;
      end
      if (wr) begin
        if (pend.size() >= MAX_MSG_DW || fifo.size() + pend.size() >= BUF_DEPTH) begin
          set[4] = 1'b1;
          abandon(eop);
        end else begin
          pend.push_back(data);
          if (eop && m_eom) begin
            foreach (pend[i]) fifo.push_back(pend[i]);
            exp_len  = pend.size();
            exp_done = 1'b1;
            pend.delete();
            m_asm = 1'b0;
          end
        end
      end
    end
    if (can_pop) exp_rd = fifo.pop_front();
    exp_avail = fifo.size();
    exp_err   = (exp_err & ~clr) | set;
    for (int i = 0; i < 5; i++) begin
      if (clr[i])                           exp_cnt[i] = 0;
      else if (set[i] && exp_cnt[i] < 65535) exp_cnt[i]++;
    end
    exp_ready = 1'b1;
  endtask

  task automatic idle(input int n, input bit rd, input bit [4:0] clr);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'($urandom), 3'($urandom), 8'($urandom),
                    $urandom, rd, clr);
  endtask

  task automatic send_tlp(input bit som, input bit eom, input bit [1:0] seq, input bit [2:0] tag,
                          input bit [7:0] eid, input int len, input bit [31:0] base,
                          input bit [4:0] clr_sop, input bit gaps);
    for (int i = 0; i < len; i++) begin
      if (gaps) while ($urandom_range(0, 3) == 0) idle(1, rd_pick(), 5'b0);
      if (i == 0)
        applyStimulus(1'b1, 1'b1, len == 1, som, eom, seq, tag, eid, base, rd_pick(), clr_sop);
      else
        applyStimulus(1'b1, 1'b0, i == len - 1, 1'($urandom), 1'($urandom), 2'($urandom),
                      3'($urandom), 8'($urandom), base + 32'(i), rd_pick(), 5'b0);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    vdm_valid = 0; vdm_sop = 0; vdm_eop = 0; vdm_som = 0; vdm_eom = 0; vdm_seq = 0;
    vdm_tag = 0; vdm_src_eid = 0; vdm_data = 0; rd_en = 0; err_clr = 0;
    fifo.delete(); pend.delete();
    m_asm = 0; m_drop = 0;
    exp_ready = 0; exp_done = 0; exp_avail = 0; exp_len = 0; exp_err = 0; exp_rd = 0;
    for (int i = 0; i < 5; i++) exp_cnt[i] = 0;
    last_len = 0;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    exp_ready = 1'b1;
  endtask

  initial begin
    int done_before;
    n_vec = 0; n_err = 0; done_cnt = 0; rd_prob = 0; chk_en = 1'b0;
    rst_n = 1'b0;
    doReset();

    // Three 16-DW TLPs forming one 48-DW message, then read back in order.
    send_tlp(1, 0, 2'd0, 3'd5, 8'h11, 16, 32'hA000_0000, 5'b0, 0);
    send_tlp(0, 0, 2'd1, 3'd5, 8'h11, 16, 32'hA000_0010, 5'b0, 0);
    send_tlp(0, 1, 2'd2, 3'd5, 8'h11, 16, 32'hA000_0020, 5'b0, 0);
    idle(1, 0, 5'b0);
    cmp("req033_msg_len", longint'(last_len), 48);
    cmp("req033_rd_avail", longint'(rd_avail), 48);
    idle(48, 1, 5'b0);
    idle(1, 0, 5'b0);
    cmp("req033_last_dw", longint'(rd_data), 64'hA000_002F);
    cmp("req033_drained", longint'(rd_avail), 0);

    // Wrong sequence number on the second TLP.
    done_before = done_cnt;
    send_tlp(1, 0, 2'd0, 3'd2, 8'h22, 4, 32'hB000_0000, 5'b0, 0);
    send_tlp(0, 1, 2'd3, 3'd2, 8'h22, 4, 32'hB000_0004, 5'b0, 0);
    idle(1, 0, 5'b0);
    cmp("req034_err_sts", longint'(err_sts), 64'h04);
    cmp("req034_rd_avail", longint'(rd_avail), 0);
    cmp("req034_no_done", longint'(done_cnt), longint'(done_before));

    // Early som restarts the message.
    idle(1, 0, 5'h1f);
    send_tlp(1, 0, 2'd0, 3'd1, 8'h33, 8, 32'hC000_0000, 5'b0, 0);
    send_tlp(1, 1, 2'd0, 3'd1, 8'h33, 4, 32'hC000_0100, 5'b0, 0);
    idle(1, 0, 5'b0);
    cmp("req035_err_sts", longint'(err_sts), 64'h02);
    cmp("req035_msg_len", longint'(last_len), 4);
    cmp("req035_rd_avail", longint'(rd_avail), 4);
    idle(5, 1, 5'h1f);

    // Oversized message: overflow on DW 257, then a clean message.
    for (int t = 0; t < 17; t++)
      send_tlp(t == 0, t == 16, 2'(t), 3'd6, 8'h44, 16, 32'hD000_0000 + 32'(t * 16), 5'b0, 0);
    idle(1, 0, 5'b0);
    cmp("req036_ovf", longint'(err_sts[4]), 1);
    cmp("req036_rd_avail", longint'(rd_avail), 0);
    send_tlp(1, 0, 2'd2, 3'd6, 8'h44, 5, 32'hD100_0000, 5'b0, 0);
    send_tlp(0, 1, 2'd3, 3'd6, 8'h44, 5, 32'hD100_0005, 5'b0, 0);
    idle(1, 0, 5'b0);
    cmp("req036_next_len", longint'(last_len), 10);
    cmp("req036_next_avail", longint'(rd_avail), 10);
    idle(11, 1, 5'b0);

    // Clear of the seq flag in the same cycle as a new seq error.
    send_tlp(1, 0, 2'd0, 3'd3, 8'h55, 2, 32'hE000_0000, 5'b0, 0);
    send_tlp(0, 1, 2'd2, 3'd3, 8'h55, 2, 32'hE000_0002, 5'b00100, 0);
    idle(1, 0, 5'b0);
    cmp("req037_seq_sticky", longint'(err_sts[2]), 1);
`ifdef PMCI_VDM_ERR_CNT_EN
    cmp("req037_seq_cnt", longint'(err_cnt[47:32]), 0);
`endif

    // Reset in the middle of a message's second TLP.
    send_tlp(1, 0, 2'd0, 3'd4, 8'h66, 8, 32'hF000_0000, 5'b0, 0);
    for (int i = 0; i < 3; i++)
      applyStimulus(1, i == 0, 0, 0, 0, 2'd1, 3'd4, 8'h66, 32'hF000_0008 + 32'(i), 0, 5'b0);
    doReset();
    send_tlp(1, 1, 2'd0, 3'd4, 8'h66, 4, 32'hF100_0000, 5'b0, 0);
    idle(1, 0, 5'b0);
    cmp("req038_msg_len", longint'(last_len), 4);
    cmp("req038_rd_avail", longint'(rd_avail), 4);

    // Randomized message streams with occasional header corruption and varying read rates.
    for (int m = 0; m < 220; m++) begin
      int ntlp, len, pr;
      bit [2:0] tg, tg2;
      bit [7:0] ed, ed2;
      bit [1:0] sq, s;
      bit som, eom;
      bit [4:0] clr;
      if (m % 70 == 69) doReset();
      pr = int'($urandom_range(0, 2));
      rd_prob = (pr == 0) ? 0 : (pr == 1) ? 25 : 70;
      ntlp = ($urandom_range(0, 9) == 0) ? int'($urandom_range(15, 18)) : int'($urandom_range(1, 4));
      tg = 3'($urandom);  ed = 8'($urandom);  sq = 2'($urandom);
      for (int t = 0; t < ntlp; t++) begin
        som = (t == 0) ^ ($urandom_range(0, 19) == 0);
        eom = (t == ntlp - 1) ^ ($urandom_range(0, 24) == 0);
        s   = sq + 2'(t);
        if ($urandom_range(0, 19) == 0) s = s + 2'($urandom_range(1, 3));
        tg2 = ($urandom_range(0, 24) == 0) ? tg ^ 3'($urandom_range(1, 7)) : tg;
        ed2 = ($urandom_range(0, 24) == 0) ? ed ^ 8'($urandom_range(1, 255)) : ed;
        len = (ntlp > 4) ? 16 : int'($urandom_range(1, 16));
        clr = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'b0;
        send_tlp(som, eom, s, tg2, ed2, len, $urandom, clr, 1);
      end
    end
    idle(2, 0, 5'b0);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pmci_vdm_msg_assembler.md
PMCI_VDM_MSG_ASSEMBLER -- requirements
Module: pmci_vdm_msg_assembler

Interface
REQ-001 SHALL have parameter BUF_DEPTH, default 512, payload buffer depth in DWs (power of 2).
REQ-002 SHALL have parameter MAX_MSG_DW, default 256, maximum reassembled message length in DWs.
REQ-003 SHALL have port clk  input  1  the single clock for all logic.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port vdm_valid  input  1  VDM payload beat valid.
REQ-006 SHALL have port vdm_ready  output  1  beat accepted when vdm_valid and vdm_ready are both high.
REQ-007 SHALL have port vdm_data  input  32  payload DW.
REQ-008 SHALL have ports vdm_sop and vdm_eop  input  1 each  first and last beat of a TLP; a one-beat TLP asserts both.
REQ-009 SHALL have ports vdm_som, vdm_eom  input  1 each; vdm_seq  input  2; vdm_tag  input  3; vdm_src_eid  input  8.  These are MCTP header fields, sampled only on the sop beat.
REQ-010 SHALL have port rd_en  input  1  pops one committed DW (PMCI_VDM_PDR read).
REQ-011 SHALL have port rd_data  output  32  popped DW, valid on the cycle after rd_en.
REQ-012 SHALL have port rd_avail  output  $clog2(BUF_DEPTH)+1  count of committed, unread DWs (PMCI_VDM_FCR).
REQ-013 SHALL have ports msg_done  output  1  and msg_len  output  9  one-cycle pulse carrying the committed message length.
REQ-014 SHALL have port err_sts  output  5  sticky errors: [0] no_som, [1] early_som, [2] seq, [3] tag, [4] ovf.
REQ-015 SHALL have port err_clr  input  5  write-1-to-clear for err_sts (PMCI_VDM_TLP_STS2).

Function
REQ-016 SHALL implement states IDLE, ASSEMBLE and DROP.
REQ-017 SHALL drive vdm_ready high in every state once out of reset; errored data is discarded, never backpressured.
REQ-018 In IDLE, an sop beat with som=1 SHALL latch tag/src_eid, set exp_seq=seq+1 mod 4, write the beat, and enter ASSEMBLE.
REQ-019 In IDLE, an sop beat with som=0 SHALL set err_sts[0] and enter DROP; a beat that is both sop and eop SHALL return to IDLE instead.
REQ-020 In ASSEMBLE, an sop beat with som=1 SHALL set err_sts[1], rewind the write pointer to the commit pointer, and start a new message from that beat.
REQ-021 In ASSEMBLE, an sop beat whose seq!=exp_seq SHALL set err_sts[2]; one whose tag or src_eid mismatches SHALL set err_sts[3]. Seq is checked first. Either SHALL rewind and enter DROP.
REQ-022 A write that would exceed MAX_MSG_DW or fill the buffer SHALL set err_sts[4], rewind, and enter DROP; the offending DW is not written.
REQ-023 DROP SHALL discard beats through eop, then go to IDLE.
REQ-024 An accepted eop beat of a TLP with eom=1 and no error SHALL advance the commit pointer, pulse msg_done with msg_len, and return to IDLE. rd_avail updates on the next cycle.
REQ-025 Pointers SHALL wrap modulo BUF_DEPTH; fullness SHALL use an extra pointer bit.
REQ-026 rd_en with rd_avail==0 SHALL be ignored, leaving the pointer and rd_data unchanged.
REQ-027 A commit and a pop in the same cycle SHALL net correctly in rd_avail.
REQ-028 If err_clr and a set of the same bit occur in the same cycle, set SHALL win.

Reset
REQ-029 rst_n low SHALL asynchronously force state IDLE, all pointers 0, vdm_ready 0, rd_data 0, rd_avail 0, msg_done 0, msg_len 0, err_sts 0.
REQ-030 Reset mid-message SHALL discard all buffer contents; the first accepted beat after reset is treated as arriving in IDLE.

Configuration
REQ-031 With PMCI_VDM_ERR_CNT_EN defined, the block SHALL add output err_cnt (5x16 flattened, 80 bits): per-class saturating counters that reset to 0 and are cleared by the matching err_clr bit.
REQ-032 Without PMCI_VDM_ERR_CNT_EN, no counters and no err_cnt port SHALL exist; err_sts is unchanged.

Verification
REQ-033 3 TLPs of 16 DW (som/seq0, seq1, eom/seq2, tag 5) -> msg_done with msg_len=48, rd_avail=48, data read in order.
REQ-034 2-TLP message whose second TLP has seq=3 instead of 1 -> err_sts=5'b00100, rd_avail=0, no msg_done.
REQ-035 som TLP of 8 DW, then a new som TLP of 4 DW with eom -> err_sts[1]=1, msg_len=4, rd_avail=4.
REQ-036 MAX_MSG_DW=256, 17 TLPs of 16 DW -> err_sts[4]=1 on DW 257, rd_avail=0; the next valid message commits normally.
REQ-037 err_clr=5'b00100 in the same cycle as a new seq error -> err_sts[2] stays 1; with PMCI_VDM_ERR_CNT_EN, the seq counter is cleared on that cycle.
REQ-038 rst_n asserted during the 2nd TLP of a message, then one 4-DW som/eom TLP -> msg_len=4, rd_avail=4.
